timer_datapath: RTL and testbench
=================================

Name: timer_datapath

Overview:
Time-keeping datapath of the egg timer. It sits directly downstream of the timer control FSM and consumes its enables: flashEn, decEn, timeWrtEn, initValEn and minEn. It holds the minutes:seconds value in BCD, loads the value from the switches, and counts down at 1 Hz. It returns isTimeFlat to the FSM and drives the display digits plus a blanking signal for the end-of-time flash.

Parameters:
CLK_HZ, 50_000_000, clk cycles per 1 s decrement tick (bench uses 4)
FLASH_DIV, 25_000_000, clk cycles per blank toggle while flashing (bench uses 3)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
flashEn  in  1  from FSM: flash display
decEn  in  1  from FSM: count down
timeWrtEn  in  1  from FSM: write enable for time registers
initValEn  in  1  from FSM: select switch value as write data
minEn  in  1  from FSM: 1 = write minutes, 0 = write seconds
setVal  in  6  switch value, binary 0..63
isTimeFlat  out  1  time == 00:00
minTens  out  4  BCD minutes tens, registered
minOnes  out  4  BCD minutes ones, registered
secTens  out  4  BCD seconds tens, registered
secOnes  out  4  BCD seconds ones, registered
blank  out  1  1 = display off (flash phase)

Behaviour:
- Reset (reset=0, asynchronous): all digits 0, prescaler 0, flash counter 0, blank 0. isTimeFlat therefore reads 1.
- Load:
  - Fires when timeWrtEn && initValEn.
  - Clamp: v = (setVal > 59) ? 59 : setVal.
  - Convert v to BCD (tens = v/10, ones = v%10).
  - minEn=1 writes the minutes pair; minEn=0 writes the seconds pair.
  - Reloads every cycle while asserted, so the display tracks the switches live.
  - Result is visible on the outputs one cycle after the edge.
- Prescaler:
  - Counts 0..CLK_HZ-1 only while decEn=1. It is held at 0 whenever decEn=0.
  - tick = decEn && (prescaler == CLK_HZ-1). The prescaler wraps to 0 on tick.
  - First tick occurs exactly CLK_HZ cycles after decEn rises.
- Decrement on tick:
  - If sec != 0: sec-1, with a BCD borrow (ones 0 -> 9 and tens-1).
  - Else if min != 0: min-1 and sec = 59.
  - Else (00:00): hold; no underflow.
- Priority: load beats decrement in the same cycle. The prescaler still follows decEn.
- isTimeFlat: combinational from the digit registers; 1 when all four digits are 0.
  - Starting at 00:00 with decEn asserted gives isTimeFlat=1 immediately. No tick side effects.
- Flash:
  - Flash counter counts 0..FLASH_DIV-1 while flashEn=1 and toggles blank on wrap.
  - When flashEn=0: counter = 0 and blank = 0.
  - blank is first set FLASH_DIV cycles after flashEn rises.
  - Flash does not alter the digits.
- Reset mid-count or mid-flash: immediate return to reset values; no partial tick is retained.
- Digit registers never hold non-BCD values or values > 59.

Decomposition:
- Package timer_pkg holds:
  - MAX_MINSEC = 59
  - BCD digit width = 4
  - function bin6_to_bcd (clamping) for the clamp and conversion
  - function is_zero_bcd
- Sub-module bcd_mod60_counter, instantiated twice (minutes, seconds):
  - Inputs: clk, reset, load, loadVal (clamped BCD pair), dec.
  - Outputs: tens, ones, zero.
  - It handles the BCD borrow and the wrap to 59.
- The top level owns the prescaler, the sec→min borrow sequencing and the flash counter.

Test Plan:
1. Drive reset=0 for 2 cycles, then release -> digits 0,0,0,0; isTimeFlat=1; blank=0.
2. timeWrtEn=initValEn=1, minEn=0, setVal=45; then minEn=1, setVal=2 -> next cycle outputs 0,2,4,5; isTimeFlat=0.
3. Load seconds with setVal=63 -> secTens=5, secOnes=9 (clamped).
4. Time 01:00 with decEn=1 (CLK_HZ=4):
   - after 4 cycles -> 00:59
   - after a further 236 cycles -> 00:00 with isTimeFlat=1
   - 8 more cycles -> still 00:00
5. Time 00:10, decEn=1 for 3 cycles, 0 for 2, then 1 again -> no decrement until 4 cycles after re-assert, then 00:09.
6. Time 00:00, flashEn=1 (FLASH_DIV=3) -> blank 0,0,0,1,1,1,0…; then reset pulsed low mid-flash -> blank=0 at once; counter cleared.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, widths and BCD helpers for the egg-timer datapath.
package timer_pkg;

  localparam int unsigned MAX_MINSEC = 59;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SETVAL_W   = 6;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_pair_t;

  // Clamp a 6-bit switch value to 59 and split it into BCD digits.
  function automatic bcd_pair_t bin6_to_bcd(input logic [SETVAL_W-1:0] v);
    logic [SETVAL_W-1:0] c;
    bcd_pair_t           r;
    c      = (v > SETVAL_W'(MAX_MINSEC)) ? SETVAL_W'(MAX_MINSEC) : v;
    r.tens = BCD_W'(c / SETVAL_W'(10));
    r.ones = BCD_W'(c % SETVAL_W'(10));
    return r;
  endfunction

  function automatic logic is_zero_bcd(input bcd_pair_t p);
    return (p == '0);
  endfunction

endpackage

// File: rtl/timer_datapath_if.sv
// Control enables from the timer FSM and display results back out.
interface timer_datapath_if;
  import timer_pkg::*;

  logic                flashEn;
  logic                decEn;
  logic                timeWrtEn;
  logic                initValEn;
  logic                minEn;
  logic [SETVAL_W-1:0] setVal;
  logic                isTimeFlat;
  logic [BCD_W-1:0]    minTens;
  logic [BCD_W-1:0]    minOnes;
  logic [BCD_W-1:0]    secTens;
  logic [BCD_W-1:0]    secOnes;
  logic                blank;

  modport master (
    output flashEn, decEn, timeWrtEn, initValEn, minEn, setVal,
    input  isTimeFlat, minTens, minOnes, secTens, secOnes, blank
  );

  modport slave (
    input  flashEn, decEn, timeWrtEn, initValEn, minEn, setVal,
    output isTimeFlat, minTens, minOnes, secTens, secOnes, blank
  );
endinterface

// File: rtl/timer_datapath_bcd_mod60_counter.sv
// Two-digit BCD down-counter over 00..59; decrementing from 00 wraps to 59.
module bcd_mod60_counter
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  bcd_pair_t        loadVal,
  input  logic             dec,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             zero
);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_ones;
  bcd_pair_t        w_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (load) begin
      r_tens <= loadVal.tens;
      r_ones <= loadVal.ones;
    end else if (dec) begin
      if (r_ones != '0) begin
        r_ones <= r_ones - BCD_W'(1);
      end else if (r_tens != '0) begin
        r_ones <= BCD_W'(9);
        r_tens <= r_tens - BCD_W'(1);
      end else begin
        r_tens <= BCD_W'(5);
        r_ones <= BCD_W'(9);
      end
    end
  end

  assign w_val = {r_tens, r_ones};
  assign tens  = r_tens;
  assign ones  = r_ones;
  assign zero  = is_zero_bcd(w_val);

endmodule

// File: rtl/timer_datapath.sv
// Egg-timer datapath: BCD mm:ss storage, switch load, 1 Hz countdown, end flash.
module timer_datapath
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned FLASH_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  timer_datapath_if.slave    bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  logic [PW-1:0]    r_presc;
  logic [FW-1:0]    r_flash_cnt;
  logic             r_blank;

  logic             w_load;
  bcd_pair_t        w_load_val;
  logic             w_tick;
  logic             w_dec_ok;
  logic             w_sec_zero;
  logic             w_min_zero;
  logic [BCD_W-1:0] w_sec_tens;
  logic [BCD_W-1:0] w_sec_ones;
  logic [BCD_W-1:0] w_min_tens;
  logic [BCD_W-1:0] w_min_ones;

  assign w_load     = bus.timeWrtEn & bus.initValEn;
  assign w_load_val = bin6_to_bcd(bus.setVal);
  assign w_tick     = bus.decEn & (r_presc == PW'(CLK_HZ - 1));
  // A load wins over the tick; at 00:00 the tick is swallowed so nothing underflows.
  assign w_dec_ok   = w_tick & ~w_load & ~(w_sec_zero & w_min_zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (!bus.decEn || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  bcd_mod60_counter u_sec (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load & ~bus.minEn),
    .loadVal (w_load_val),
    .dec     (w_dec_ok),
    .tens    (w_sec_tens),
    .ones    (w_sec_ones),
    .zero    (w_sec_zero)
  );

  // Minutes borrow only when seconds are about to wrap from 00 to 59.
  bcd_mod60_counter u_min (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load & bus.minEn),
    .loadVal (w_load_val),
    .dec     (w_dec_ok & w_sec_zero),
    .tens    (w_min_tens),
    .ones    (w_min_ones),
    .zero    (w_min_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flash_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (!bus.flashEn) begin
      r_flash_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (r_flash_cnt == FW'(FLASH_DIV - 1)) begin
      r_flash_cnt <= '0;
      r_blank     <= ~r_blank;
    end else begin
      r_flash_cnt <= r_flash_cnt + FW'(1);
    end
  end

  assign bus.minTens    = w_min_tens;
  assign bus.minOnes    = w_min_ones;
  assign bus.secTens    = w_sec_tens;
  assign bus.secOnes    = w_sec_ones;
  assign bus.isTimeFlat = w_sec_zero & w_min_zero;
  assign bus.blank      = r_blank;

endmodule

// File: tb/tb_timer_datapath.sv
// Randomized bench for timer_datapath against a seconds-count reference model.
module tb_timer_datapath;

  localparam int CLK_HZ    = 4;
  localparam int FLASH_DIV = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  timer_datapath_if bus ();

  timer_datapath #(.CLK_HZ(CLK_HZ), .FLASH_DIV(FLASH_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Model: whole minutes/seconds plus run lengths of decEn and flashEn.
  int m_min  = 0;
  int m_sec  = 0;
  int m_run  = 0;
  int m_fcnt = 0;
  int m_blank = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_min = 0; m_sec = 0; m_run = 0; m_fcnt = 0; m_blank = 0;
    end else begin
      bit tick;
      int t;
      int v;
      tick = 1'b0;
      if (bus.decEn) begin
        m_run++;
        tick = (m_run % CLK_HZ) == 0;
      end else begin
        m_run = 0;
      end
      if (bus.timeWrtEn && bus.initValEn) begin
        v = (int'(bus.setVal) > 59) ? 59 : int'(bus.setVal);
        if (bus.minEn) m_min = v;
        else           m_sec = v;
      end else if (tick) begin
        t = m_min * 60 + m_sec;
        if (t > 0) t--;
        m_min = t / 60;
        m_sec = t % 60;
      end
      if (bus.flashEn) begin
        m_fcnt++;
        m_blank = ((m_fcnt / FLASH_DIV) % 2);
      end else begin
        m_fcnt  = 0;
        m_blank = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("minTens", int'(bus.minTens), m_min / 10);
      check("minOnes", int'(bus.minOnes), m_min % 10);
      check("secTens", int'(bus.secTens), m_sec / 10);
      check("secOnes", int'(bus.secOnes), m_sec % 10);
      check("isTimeFlat", int'(bus.isTimeFlat), (m_min == 0 && m_sec == 0) ? 1 : 0);
      check("blank", int'(bus.blank), m_blank);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_time(input string name, input int mm, input int ss);
    check({name, ".time"}, int'(bus.minTens) * 1000 + int'(bus.minOnes) * 100
                          + int'(bus.secTens) * 10 + int'(bus.secOnes),
          (mm / 10) * 1000 + (mm % 10) * 100 + (ss / 10) * 10 + (ss % 10));
  endtask

  task automatic load(input bit min_sel, input int val);
    bus.timeWrtEn = 1'b1;
    bus.initValEn = 1'b1;
    bus.minEn     = min_sel;
    bus.setVal    = 6'(val);
    cycles(1);
    bus.timeWrtEn = 1'b0;
    bus.initValEn = 1'b0;
  endtask

  int blank_exp[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    bus.flashEn = 1'b0; bus.decEn = 1'b0; bus.timeWrtEn = 1'b0;
    bus.initValEn = 1'b0; bus.minEn = 1'b0; bus.setVal = '0;
    reset = 1'b0;
    cycles(2);
    check_time("reset", 0, 0);
    check("reset.flat", int'(bus.isTimeFlat), 1);
    check("reset.blank", int'(bus.blank), 0);
    reset = 1'b1;
    chk_en = 1'b1;
    cycles(1);

    load(1'b0, 45);
    load(1'b1, 2);
    check_time("load", 2, 45);
    check("load.flat", int'(bus.isTimeFlat), 0);

    load(1'b0, 63);
    check_time("clamp", 2, 59);

    load(1'b1, 1);
    load(1'b0, 0);
    bus.decEn = 1'b1;
    cycles(4);
    check_time("first_tick", 0, 59);
    cycles(236);
    check_time("count_to_zero", 0, 0);
    check("zero.flat", int'(bus.isTimeFlat), 1);
    cycles(8);
    check_time("hold_zero", 0, 0);
    bus.decEn = 1'b0;

    load(1'b0, 10);
    bus.decEn = 1'b1;
    cycles(3);
    bus.decEn = 1'b0;
    cycles(2);
    bus.decEn = 1'b1;
    cycles(3);
    check_time("presc_restart", 0, 10);
    cycles(1);
    check_time("presc_tick", 0, 9);
    bus.decEn = 1'b0;

    load(1'b0, 0);
    bus.flashEn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycles(1);
      check($sformatf("flash%0d", i), int'(bus.blank), blank_exp[i]);
    end
    cycles(1);
    reset = 1'b0;
    #1;
    check("rst_flash.blank", int'(bus.blank), 0);
    check_time("rst_flash", 0, 0);
    bus.flashEn = 1'b0;
    cycles(1);
    reset = 1'b1;
    bus.flashEn = 1'b1;
    cycles(3);
    check("flash_after_rst", int'(bus.blank), 1);
    bus.flashEn = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      bus.setVal    = 6'($urandom_range(0, 63));
      bus.timeWrtEn = ($urandom_range(0, 15) == 0);
      bus.initValEn = bus.timeWrtEn ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      bus.minEn     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) bus.decEn = ~bus.decEn;
      if ($urandom_range(0, 29) == 0) bus.flashEn = ~bus.flashEn;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
      end
      cycles(1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
